// File: rtl/nios_irq_aggregator.sv
// nios_irq_aggregator
//   Collects up to 16 peripheral interrupt lines (line 0 = interval timer),
//   synchronises them, latches each line as level or rising-edge event,
//   masks them and drives one registered irq plus a priority vector.
//
// Ports:
//   clk        - sole clock
//   reset_n    - asynchronous active-low reset
//   address    - 3-bit register word address
//   chipselect - slave select
//   write_n    - active-low write strobe (write = chipselect && !write_n)
//   writedata  - 16-bit write data
//   readdata   - registered read data, one clock after address
//   irq_in     - interrupt source lines, active-high
//   irq        - registered aggregate interrupt to the CPU
//
// Register map: 0 PENDING (W1C edge lines), 1 MASK, 2 MODE (1 = edge),
//   3 RAW, 4 ACTIVE, 5 VECTOR, 6 FORCE (write-only), 7 reserved.
module nios_irq_aggregator #(
    parameter int unsigned N_IRQ       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [15:0]       writedata,
    output logic [15:0]       readdata,
    input  logic [N_IRQ-1:0]  irq_in,
    output logic              irq
);

    localparam logic [2:0] ADDR_PENDING = 3'd0;
    localparam logic [2:0] ADDR_MASK    = 3'd1;
    localparam logic [2:0] ADDR_MODE    = 3'd2;
    localparam logic [2:0] ADDR_RAW     = 3'd3;
    localparam logic [2:0] ADDR_ACTIVE  = 3'd4;
    localparam logic [2:0] ADDR_VECTOR  = 3'd5;
    localparam logic [2:0] ADDR_FORCE   = 3'd6;

    logic              wr;
    logic              wr_pending;
    logic              wr_mask;
    logic              wr_mode;
    logic              wr_force;
    logic [N_IRQ-1:0]  wdata;
    logic              unused_wdata;

    logic [N_IRQ-1:0]  sync;
    logic [N_IRQ-1:0]  prev;
    logic [N_IRQ-1:0]  rise;
    logic [N_IRQ-1:0]  pending;
    logic [N_IRQ-1:0]  pending_next;
    logic [N_IRQ-1:0]  mask;
    logic [N_IRQ-1:0]  mode;
    logic [N_IRQ-1:0]  active;
    logic [3:0]        vec_idx;
    logic              vec_any;
    logic [15:0]       rd_mux;

    assign wr         = chipselect && !write_n;
    assign wr_pending = wr && (address == ADDR_PENDING);
    assign wr_mask    = wr && (address == ADDR_MASK);
    assign wr_mode    = wr && (address == ADDR_MODE);
    assign wr_force   = wr && (address == ADDR_FORCE);
    // Bits at or above N_IRQ are simply dropped.
    assign wdata        = writedata[N_IRQ-1:0];
    assign unused_wdata = ^writedata;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sync = irq_in;
        end else begin : g_sync
            logic [N_IRQ-1:0] stage [SYNC_STAGES];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int unsigned s = 0; s < SYNC_STAGES; s++)
                        stage[s] <= '0;
                end else begin
                    stage[0] <= irq_in;
                    for (int unsigned s = 1; s < SYNC_STAGES; s++)
                        stage[s] <= stage[s-1];
                end
            end

            assign sync = stage[SYNC_STAGES-1];
        end
    endgenerate

    assign rise   = sync & ~prev;
    assign active = pending & mask;

    // Decisions use the mode in force before this edge. A 0->1 MODE write
    // clears the bit; since prev already tracks a high line, only a fresh
    // rising edge can set it afterwards. On a 1->0 write the line still
    // behaves as edge-mode for this one edge, then follows sync.
    always_comb begin
        pending_next = pending;
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            if (!mode[i]) begin
                if (wr_mode && wdata[i])
                    pending_next[i] = 1'b0;
                else
                    pending_next[i] = sync[i];
            end else begin
                // Set has priority over W1C so no event is lost.
                if (rise[i] || (wr_force && wdata[i]))
                    pending_next[i] = 1'b1;
                else if (wr_pending && wdata[i])
                    pending_next[i] = 1'b0;
            end
        end
    end

    // Lowest-numbered active line wins.
    always_comb begin
        vec_idx = '0;
        vec_any = 1'b0;
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            if (active[i] && !vec_any) begin
                vec_idx = 4'(i);
                vec_any = 1'b1;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_PENDING: rd_mux = 16'(pending);
            ADDR_MASK:    rd_mux = 16'(mask);
            ADDR_MODE:    rd_mux = 16'(mode);
            ADDR_RAW:     rd_mux = 16'(sync);
            ADDR_ACTIVE:  rd_mux = 16'(active);
            ADDR_VECTOR:  rd_mux = vec_any ? {1'b1, 11'b0, vec_idx} : 16'h0000;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev     <= '0;
            pending  <= '0;
            mask     <= '0;
            mode     <= '0;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            prev     <= sync;
            pending  <= pending_next;
            if (wr_mask)
                mask <= wdata;
            if (wr_mode)
                mode <= wdata;
            irq      <= |active;
            readdata <= rd_mux;
        end
    end

endmodule
